// File: rtl/led_cmd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : led_cmd_pkg                                            |
// | Description : Command codes and shared defaults used by the button   |
// |               command encoder and the LED controller.                |
// | Contents    : cmd_e              - 2-bit LED command encoding        |
// |               DEBOUNCE_CYCLES_DEFAULT - 10 ms at 27 MHz              |
// |               NUM_BUTTONS        - number of front-panel buttons     |
// |               btn_to_cmd()       - button index to command code      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package led_cmd_pkg;

   typedef enum logic [1:0] {
      CMD_ON    = 2'd0,
      CMD_OFF   = 2'd1,
      CMD_BLINK = 2'd2,
      CMD_SHIFT = 2'd3
   } cmd_e;

   localparam int DEBOUNCE_CYCLES_DEFAULT = 270_000;
   localparam int NUM_BUTTONS             = 4;

   // Button i is wired to command code i.
   function automatic cmd_e btn_to_cmd(input logic [1:0] idx);
      return cmd_e'(idx);
   endfunction

endpackage
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : button_debounce                                        |
// | Description : 2-flop synchronizer, counter debouncer and press-edge  |
// |               detector for one active-low push button.               |
// | Ports       : clk      - clock, rising edge                          |
// |               rst      - synchronous active-high reset               |
// |               btn_n_i  - raw asynchronous button, 0 = pressed        |
// |               level_o  - debounced level, 1 = pressed                |
// |               press_o  - one-cycle pulse on released->pressed        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module button_debounce
   import led_cmd_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_n_i,
   output logic level_o,
   output logic press_o
);

   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q;
   logic             sync2_q;
   logic             level_q;
   logic             level_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             press_q;
   logic             press_d;
   logic             pressed_w;

   // Synchronizer flops idle at 1 (released) so a button held through
   // reset is seen as a fresh press that must be debounced again.
   assign pressed_w = ~sync2_q;

   always_comb begin
      level_d = level_q;
      cnt_d   = cnt_q;
      press_d = 1'b0;
      if (pressed_w == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         // Input has differed for DEBOUNCE_CYCLES consecutive cycles.
         level_d = pressed_w;
         cnt_d   = '0;
         press_d = pressed_w;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         level_q <= 1'b0;
         cnt_q   <= '0;
         press_q <= 1'b0;
      end else begin
         sync1_q <= btn_n_i;
         sync2_q <= sync1_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
         press_q <= press_d;
      end
   end

   assign level_o = level_q;
   assign press_o = press_q;

endmodule
`default_nettype wire

// File: rtl/button_cmd_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : button_cmd_encoder                                     |
// | Description : Debounces four active-low buttons, turns each press    |
// |               into an LED command and queues it in a small FIFO with |
// |               a valid/ready output and a sticky overflow flag.       |
// | Ports       : clk       - clock, rising edge                         |
// |               rst       - synchronous active-high reset              |
// |               button    - raw buttons, active-low                    |
// |               cmd_valid - FIFO not empty                             |
// |               cmd_ready - consumer accepts cmd_code                  |
// |               cmd_code  - FIFO head (0=ON 1=OFF 2=BLINK 3=SHIFT)     |
// |               btn_state - debounced levels, 1 = pressed              |
// |               overflow  - sticky: a press was dropped on a full FIFO |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module button_cmd_encoder
   import led_cmd_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] button,
   output logic       cmd_valid,
   input  logic       cmd_ready,
   output logic [1:0] cmd_code,
   output logic [3:0] btn_state,
   output logic       overflow
);

   localparam int               PTR_W    = $clog2(FIFO_DEPTH);
   localparam int               OCC_W    = $clog2(FIFO_DEPTH) + 1;
   localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

   logic [NUM_BUTTONS-1:0] press_w;

   logic                   push_d;
   logic                   push_q;
   cmd_e                   push_code_d;
   cmd_e                   push_code_q;

   cmd_e                   mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]       wr_ptr_q;
   logic [PTR_W-1:0]       wr_ptr_d;
   logic [PTR_W-1:0]       rd_ptr_q;
   logic [PTR_W-1:0]       rd_ptr_d;
   logic [OCC_W-1:0]       occ_q;
   logic [OCC_W-1:0]       occ_d;
   logic                   ovf_q;
   logic                   ovf_d;

   logic                   full_w;
   logic                   pop_w;
   logic                   wr_en_w;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_BUTTONS; gi++) begin : g_btn
         button_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
         ) u_debounce (
            .clk     (clk),
            .rst     (rst),
            .btn_n_i (button[gi]),
            .level_o (btn_state[gi]),
            .press_o (press_w[gi])
         );
      end
   endgenerate

   // Lowest-index press wins; the others in the same cycle are discarded
   // silently (they are not overflow events).
   always_comb begin
      push_d      = 1'b0;
      push_code_d = CMD_ON;
      for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
         if (press_w[i]) begin
            push_d      = 1'b1;
            push_code_d = btn_to_cmd(2'(i));
         end
      end
   end

   assign full_w    = (occ_q == OCC_FULL);
   assign cmd_valid = (occ_q != '0);
   assign pop_w     = cmd_valid & cmd_ready;
   // A pop in the same cycle frees the slot, so full only blocks a lone push.
   assign wr_en_w   = push_q & (~full_w | pop_w);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      ovf_d    = ovf_q;
      if (wr_en_w) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop_w) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (wr_en_w && !pop_w) begin
         occ_d = occ_q + OCC_W'(1);
      end else if (!wr_en_w && pop_w) begin
         occ_d = occ_q - OCC_W'(1);
      end
      if (push_q && !wr_en_w) begin
         ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         push_q      <= 1'b0;
         push_code_q <= CMD_ON;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         occ_q       <= '0;
         ovf_q       <= 1'b0;
      end else begin
         push_q      <= push_d;
         push_code_q <= push_code_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         occ_q       <= occ_d;
         ovf_q       <= ovf_d;
      end
   end

   // Storage needs no reset: entries are only visible while occupancy > 0.
   always_ff @(posedge clk) begin
      if (wr_en_w) begin
         mem_q[wr_ptr_q] <= push_code_q;
      end
   end

   assign cmd_code = cmd_valid ? mem_q[rd_ptr_q] : CMD_ON;
   assign overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_button_cmd_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_button_cmd_encoder                                  |
// | Description : Self-checking bench for button_cmd_encoder with        |
// |               DEBOUNCE_CYCLES=4, FIFO_DEPTH=4.                       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_button_cmd_encoder;

   localparam int DEB   = 4;
   localparam int DEPTH = 4;

   logic       clk;
   logic       rst;
   logic [3:0] button;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_code;
   logic [3:0] btn_state;
   logic       overflow;

   int n_checks = 0;
   int n_pass   = 0;

   button_cmd_encoder #(
      .DEBOUNCE_CYCLES (DEB),
      .FIFO_DEPTH      (DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .button    (button),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_code  (cmd_code),
      .btn_state (btn_state),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endfunction

   // ------------------------------------------------------------------
   // Behavioural model: input seen two clocks late; level flips after it
   // has disagreed for DEB consecutive clocks; a press becomes a queued
   // command two clocks after the level flips; queue holds DEPTH codes.
   // ------------------------------------------------------------------
   bit   [3:0] m_s1 = 4'hF;
   bit   [3:0] m_s2 = 4'hF;
   bit   [3:0] m_lvl = 4'h0;
   int         m_run [4];
   bit   [3:0] m_ev = 4'h0;
   bit         m_push_v = 1'b0;
   logic [1:0] m_push_code = 2'd0;
   logic [1:0] m_q [$];
   bit         m_ovf = 1'b0;
   bit         m_live = 1'b0;

   bit         pop_m;
   bit         full_m;
   bit   [3:0] new_ev;

   always @(posedge clk) begin
      if (rst) begin
         m_s1 = 4'hF;
         m_s2 = 4'hF;
         m_lvl = 4'h0;
         for (int i = 0; i < 4; i++) m_run[i] = 0;
         m_ev = 4'h0;
         m_push_v = 1'b0;
         m_q.delete();
         m_ovf = 1'b0;
      end else begin
         pop_m  = (m_q.size() > 0) && cmd_ready;
         full_m = (m_q.size() == DEPTH);
         if (pop_m) void'(m_q.pop_front());
         if (m_push_v) begin
            if (!full_m || pop_m) m_q.push_back(m_push_code);
            else m_ovf = 1'b1;
         end
         m_push_v = 1'b0;
         for (int i = 0; i < 4; i++) begin
            if (m_ev[i] && !m_push_v) begin
               m_push_v    = 1'b1;
               m_push_code = 2'(i);
            end
         end
         new_ev = 4'h0;
         for (int i = 0; i < 4; i++) begin
            if (!m_s2[i] == m_lvl[i]) m_run[i] = 0;
            else begin
               m_run[i]++;
               if (m_run[i] == DEB) begin
                  m_lvl[i]  = ~m_lvl[i];
                  m_run[i]  = 0;
                  new_ev[i] = m_lvl[i];
               end
            end
         end
         m_ev = new_ev;
         m_s2 = m_s1;
         m_s1 = button;
      end
      m_live = 1'b1;
   end

   // DUT deliveries observed by the bench.
   logic [1:0] dut_del [$];

   always @(negedge clk) begin
      if (m_live) begin
         check("valid", 32'(cmd_valid), 32'(m_q.size() > 0));
         check("code", 32'(cmd_code), 32'((m_q.size() > 0) ? m_q[0] : 2'd0));
         check("btn_state", 32'(btn_state), 32'(m_lvl));
         check("overflow", 32'(overflow), 32'(m_ovf));
         if (cmd_valid === 1'b1 && cmd_ready === 1'b1) dut_del.push_back(cmd_code);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   initial begin
      rst = 1'b1; button = 4'hF; cmd_ready = 1'b0;
      tick(2);
      check("rst_valid", 32'(cmd_valid), 32'd0);
      check("rst_code", 32'(cmd_code), 32'd0);
      check("rst_btn", 32'(btn_state), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
      rst = 1'b0; cmd_ready = 1'b1;
      tick(2);

      // Clean press of button 2, held 10 cycles.
      dut_del.delete();
      button = 4'b1011;
      tick(5);
      check("press_lvl_early", 32'(btn_state[2]), 32'd0);
      tick(1);
      check("press_lvl_on", 32'(btn_state[2]), 32'd1);
      tick(4);
      button = 4'hF;
      tick(14);
      check("press_count", 32'(dut_del.size()), 32'd1);
      if (dut_del.size() > 0) check("press_code", 32'(dut_del[0]), 32'd2);
      check("press_released", 32'(btn_state), 32'd0);

      // Glitch: 3 cycles low is too short.
      dut_del.delete();
      button = 4'b1110;
      tick(3);
      button = 4'hF;
      tick(10);
      check("glitch_count", 32'(dut_del.size()), 32'd0);
      check("glitch_btn", 32'(btn_state), 32'd0);

      // Backpressure: five presses of button 3 into a depth-4 queue.
      dut_del.delete();
      cmd_ready = 1'b0;
      repeat (5) begin
         button = 4'b0111; tick(8);
         button = 4'hF;    tick(8);
      end
      tick(4);
      check("bp_valid", 32'(cmd_valid), 32'd1);
      check("bp_code", 32'(cmd_code), 32'd3);
      check("bp_ovf", 32'(overflow), 32'd1);
      cmd_ready = 1'b1;
      tick(10);
      check("bp_count", 32'(dut_del.size()), 32'd4);
      foreach (dut_del[k]) check("bp_del_code", 32'(dut_del[k]), 32'd3);
      check("bp_drained", 32'(cmd_valid), 32'd0);
      check("bp_ovf_sticky", 32'(overflow), 32'd1);

      // Simultaneous press of buttons 0, 1 and 3.
      rst = 1'b1; tick(1); rst = 1'b0;
      check("ovf_cleared", 32'(overflow), 32'd0);
      dut_del.delete();
      button = 4'b0100;
      tick(8);
      button = 4'hF;
      tick(10);
      check("simul_count", 32'(dut_del.size()), 32'd1);
      if (dut_del.size() > 0) check("simul_code", 32'(dut_del[0]), 32'd0);
      check("simul_ovf", 32'(overflow), 32'd0);

      // Full queue with push and pop coinciding.
      dut_del.delete();
      cmd_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         button = ~(4'b0001 << i); tick(8);
         button = 4'hF;            tick(8);
      end
      check("full_valid", 32'(cmd_valid), 32'd1);
      check("full_head", 32'(cmd_code), 32'd0);
      button = 4'b1101;
      tick(7);
      cmd_ready = 1'b1;
      tick(1);
      button = 4'hF;
      tick(16);
      check("full_count", 32'(dut_del.size()), 32'd5);
      if (dut_del.size() == 5) begin
         check("full_first", 32'(dut_del[0]), 32'd0);
         check("full_last", 32'(dut_del[4]), 32'd1);
      end
      check("full_ovf", 32'(overflow), 32'd0);

      // Reset with two entries queued; button 0 held across reset.
      dut_del.delete();
      cmd_ready = 1'b0;
      button = 4'b1011; tick(8); button = 4'hF; tick(8);
      button = 4'b0111; tick(8); button = 4'hF; tick(8);
      check("mid_valid", 32'(cmd_valid), 32'd1);
      check("mid_code", 32'(cmd_code), 32'd2);
      button = 4'b1110;
      tick(2);
      rst = 1'b1; tick(1); rst = 1'b0;
      check("mid_rst_valid", 32'(cmd_valid), 32'd0);
      check("mid_rst_btn", 32'(btn_state), 32'd0);
      cmd_ready = 1'b1;
      tick(12);
      button = 4'hF;
      tick(12);
      check("mid_count", 32'(dut_del.size()), 32'd1);
      if (dut_del.size() > 0) check("mid_code_after", 32'(dut_del[0]), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/button_cmd_encoder.md
BUTTON_CMD_ENCODER -- requirements
Module: button_cmd_encoder

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 270_000, meaning the stable-level cycles required before a button change is accepted (10 ms at 27 MHz).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning the command queue depth (power of two, >= 2).
REQ-003 SHALL have port clk  input  1  meaning the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst  input  1  meaning the reset; it is synchronous and active-high.
REQ-005 SHALL have port button  input  4  meaning the raw asynchronous buttons; they are active-low, so 0 = pressed.
REQ-006 SHALL have port cmd_valid  output  1  meaning a command is present on cmd_code.
REQ-007 SHALL have port cmd_ready  input  1  meaning the consumer accepts the command.
REQ-008 SHALL have port cmd_code  output  2  meaning the command: 0=ON, 1=OFF, 2=BLINK, 3=SHIFT.
REQ-009 SHALL have port btn_state  output  4  meaning the debounced levels; they are active-high, so 1 = pressed.
REQ-010 SHALL have port overflow  output  1  meaning a sticky flag that a press event was dropped.

Function
REQ-011 SHALL pass each button bit through a 2-flop synchronizer before any other use.
REQ-012 SHALL keep, per button, a debounced level and a counter of width clog2(DEBOUNCE_CYCLES)+1.
- Counter clears whenever the synchronized input equals the debounced level.
- Otherwise the counter increments.
REQ-013 SHALL update the debounced level on the cycle the counter reaches DEBOUNCE_CYCLES-1 with the input still differing, and clear the counter on that same cycle.
- A glitch shorter than DEBOUNCE_CYCLES cycles never changes the level.
REQ-014 SHALL generate a one-cycle press event when a debounced level goes released to pressed; release edges generate no event.
REQ-015 SHALL map a button[i] press to cmd_code i.
REQ-016 SHALL, on simultaneous press events in one cycle, enqueue only the lowest-index button's event and discard the others without setting overflow.
REQ-017 SHALL push the event into a FIFO of FIFO_DEPTH entries on the cycle after the event pulse.
- cmd_valid asserts the following cycle if the FIFO was empty.
REQ-018 SHALL drive cmd_valid = FIFO not empty and cmd_code = FIFO head.
- A transfer occurs on any cycle with cmd_valid && cmd_ready.
REQ-019 SHALL hold cmd_code stable while cmd_valid && !cmd_ready.
REQ-020 SHALL ignore cmd_ready when the FIFO is empty.
REQ-021 SHALL, when a push arrives with the FIFO full and no pop in that cycle, drop the push and set overflow.
REQ-022 SHALL, when a push and a pop coincide with the FIFO full, accept both and leave the occupancy unchanged.
REQ-023 SHALL, when a push and a pop coincide with the FIFO empty, deliver the pushed entry on the next cycle.
REQ-024 SHALL wrap the FIFO read/write pointers modulo FIFO_DEPTH.
- Full/empty is determined by a separate occupancy count of width clog2(FIFO_DEPTH)+1.
REQ-025 SHALL clear overflow only by reset.

Reset
REQ-026 SHALL, while rst=1 at a clock edge, set:
- synchronizer flops to 1;
- debounced levels to released;
- counters to 0;
- FIFO pointers and occupancy to 0;
- overflow to 0.
REQ-027 SHALL drive cmd_valid=0, cmd_code=0, btn_state=0 and overflow=0 in the cycle after reset is sampled.
REQ-028 SHALL discard all queued commands and any partially elapsed debounce when reset occurs mid-operation.
REQ-029 SHALL produce no press event for a button held pressed through reset release until that button has been debounced as pressed after reset (DEBOUNCE_CYCLES after sync), then produce exactly one event.

Structure
REQ-030 SHALL take the command codes (CMD_ON, CMD_OFF, CMD_BLINK, CMD_SHIFT) and the default DEBOUNCE_CYCLES from shared package led_cmd_pkg, which the LED controller also imports.
REQ-031 SHALL implement synchronizer plus debounce plus press-edge detection in sub-module button_debounce, instantiated 4 times; FIFO and priority logic stay in the top.

Verification (DEBOUNCE_CYCLES=4, FIFO_DEPTH=4)
REQ-032 SHALL cover a clean press:
- stimulus: button=4'b1011 held 10 cycles, cmd_ready=1;
- response: exactly one cmd_valid pulse with cmd_code=2, and btn_state[2]=1 from sync+4 cycles on.
REQ-033 SHALL cover a glitch:
- stimulus: button[0] low for 3 cycles then high;
- response: no cmd_valid, btn_state stays 0.
REQ-034 SHALL cover backpressure and overflow:
- stimulus: cmd_ready=0, 5 sequential separated presses of button[3];
- response: occupancy 4, cmd_code=3 stable, overflow=1;
- then cmd_ready=1: response is exactly 4 transfers, then cmd_valid=0.
REQ-035 SHALL cover a simultaneous press:
- stimulus: button=4'b0100 in one cycle;
- response: one command, cmd_code=0, overflow=0.
REQ-036 SHALL cover full with concurrent push and pop:
- stimulus: FIFO full, cmd_ready=1 on the push cycle;
- response: no overflow, and the new code is delivered last.
REQ-037 SHALL cover reset mid-queue:
- stimulus: 2 entries queued, rst=1 for 1 cycle;
- response: cmd_valid=0 the next cycle and no stale command is delivered afterwards.
